// File: rtl/alu_exec_unit.sv
// Execute/writeback sequencer for a 32x32 register file: accepts one ALU op at a time,
// reads operands, executes (single-cycle or 32-step shift-add multiply), writes back.
module alu_exec_unit #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int MUL_CYCLES = 32
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [ADDR_W-1:0] in_rd,
  output logic [ADDR_W-1:0] readreg1,
  output logic [ADDR_W-1:0] readreg2,
  input  logic [DATA_W-1:0] read1,
  input  logic [DATA_W-1:0] read2,
  output logic [ADDR_W-1:0] writereg,
  output logic [DATA_W-1:0] data,
  output logic              regwrite,
  output logic              busy,
  output logic              done
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SLL  = 4'd5,
    OP_SRL  = 4'd6,
    OP_SRA  = 4'd7,
    OP_SLT  = 4'd8,
    OP_SLTU = 4'd9,
    OP_MUL  = 4'd10
  } op_t;

  state_t              r_state;
  state_t              w_next;
  op_t                 r_op;
  logic [ADDR_W-1:0]   r_rs1;
  logic [ADDR_W-1:0]   r_rs2;
  logic [ADDR_W-1:0]   r_rd;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_b;
  logic [DATA_W-1:0]   r_result;
  logic [CNT_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   w_alu;
  logic                w_wb_en;

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clr) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every always_comb output is given a default first so no path infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = S_READ;
      S_READ: w_next = S_EXEC;
      S_EXEC: if (r_op != OP_MUL || r_cnt == CNT_LAST) w_next = S_WB;
      S_WB:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Single-cycle ALU over the captured operands; undefined opcodes yield zero.
  always_comb begin
    w_alu = '0;
    case (r_op)
      OP_ADD:  w_alu = r_a + r_b;
      OP_SUB:  w_alu = r_a - r_b;
      OP_AND:  w_alu = r_a & r_b;
      OP_OR:   w_alu = r_a | r_b;
      OP_XOR:  w_alu = r_a ^ r_b;
      OP_SLL:  w_alu = r_a << r_b[SH_W-1:0];
      OP_SRL:  w_alu = r_a >> r_b[SH_W-1:0];
      OP_SRA:  w_alu = $signed(r_a) >>> r_b[SH_W-1:0];
      OP_SLT:  w_alu = {{(DATA_W-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
      OP_SLTU: w_alu = {{(DATA_W-1){1'b0}}, (r_a < r_b)};
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_op     <= OP_ADD;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_rd     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_result <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op  <= op_t'(in_op);
            r_rs1 <= in_rs1;
            r_rs2 <= in_rs2;
            r_rd  <= in_rd;
          end
        end
        S_READ: begin
          r_a      <= read1;
          r_b      <= read2;
          r_cnt    <= '0;
          r_result <= '0;
        end
        S_EXEC: begin
          if (r_op == OP_MUL) begin
            // r_result doubles as the shift-add accumulator.
            if (r_b[0]) r_result <= r_result + r_a;
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            r_result <= w_alu;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode registered state only; r_rs1/r_rs2 change only on accept, so they hold outside READ.
  assign w_wb_en = (r_state == S_WB) && (r_rd != '0);

  always_comb begin
    in_ready = (r_state == S_IDLE);
    busy     = (r_state != S_IDLE);
    done     = (r_state == S_WB);
    readreg1 = r_rs1;
    readreg2 = r_rs2;
    regwrite = w_wb_en;
    writereg = w_wb_en ? r_rd : '0;
    data     = w_wb_en ? r_result : '0;
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a behavioural register file (comb read, negedge write).
module tb_alu_exec_unit;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_op = '0;
  logic [AW-1:0] in_rs1 = '0, in_rs2 = '0, in_rd = '0;
  logic [AW-1:0] readreg1, readreg2, writereg;
  logic [DW-1:0] read1, read2, data;
  logic          regwrite, busy, done;

  logic [DW-1:0] rf   [32];
  logic [DW-1:0] snap [32];

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.DATA_W(DW), .ADDR_W(AW), .MUL_CYCLES(32)) dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .readreg1(readreg1), .readreg2(readreg2), .read1(read1), .read2(read2),
    .writereg(writereg), .data(data), .regwrite(regwrite), .busy(busy), .done(done)
  );

  // Register file model: writes any address, so a stray write to r0 is visible.
  assign read1 = rf[readreg1];
  assign read2 = rf[readreg2];
  always @(negedge clk) if (regwrite) rf[writereg] = data;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
    string       name;
  } vec_t;

  vec_t vecs [15];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one instruction and follow it to WB, checking latency, WB outputs and idle-after.
  task automatic run_instr(input logic [3:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input int exp_lat, input logic [31:0] exp_data,
                           input string name);
    int cyc;
    int wb_cyc;
    bit pre_ok;
    @(negedge clk);
    check({name, " in_ready before issue"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_op = op; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    tick();
    in_valid = 1'b0;
    cyc = 1; wb_cyc = 0; pre_ok = 1'b1;
    while (cyc <= 60 && wb_cyc == 0) begin
      if (done) begin
        wb_cyc = cyc;
        check({name, " regwrite"}, 32'(regwrite), (rd != 0) ? 32'd1 : 32'd0);
        check({name, " writereg"}, 32'(writereg), (rd != 0) ? 32'(rd) : 32'd0);
        check({name, " data"}, data, (rd != 0) ? exp_data : 32'd0);
      end else begin
        if (!busy || in_ready || regwrite || writereg != 0 || data != 0) pre_ok = 1'b0;
        tick();
        cyc++;
      end
    end
    check({name, " WB cycle"}, 32'(wb_cyc), 32'(exp_lat));
    check({name, " quiet/busy before WB"}, 32'(pre_ok), 32'd1);
    tick();
    check({name, " done width 1"}, 32'(done), 32'd0);
    check({name, " in_ready after WB"}, 32'(in_ready), 32'd1);
    check({name, " rf[rd]"}, rf[rd], (rd != 0) ? exp_data : 32'd0);
  endtask

  initial begin
    int d1, d2, ndone;
    logic [31:0] dat1, dat2;
    logic [4:0]  wr1, wr2;
    bit same;

    for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + 32'(i);
    rf[0] = '0;

    vecs[0]  = '{4'd0,  5'd3, 32'd7,        32'd5,        32'd12,         3,  "ADD"};
    vecs[1]  = '{4'd1,  5'd3, 32'd5,        32'd7,        32'hFFFF_FFFE,  3,  "SUB wrap"};
    vecs[2]  = '{4'd2,  5'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000,   3,  "AND"};
    vecs[3]  = '{4'd3,  5'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0,   3,  "OR"};
    vecs[4]  = '{4'd4,  5'd3, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0,   3,  "XOR"};
    vecs[5]  = '{4'd5,  5'd3, 32'd1,        32'h24,       32'h10,         3,  "SLL low5"};
    vecs[6]  = '{4'd7,  5'd4, 32'h80000000, 32'd4,        32'hF8000000,   3,  "SRA"};
    vecs[7]  = '{4'd6,  5'd4, 32'h80000000, 32'd4,        32'h08000000,   3,  "SRL"};
    vecs[8]  = '{4'd8,  5'd4, 32'h80000000, 32'd4,        32'd1,          3,  "SLT neg"};
    vecs[9]  = '{4'd9,  5'd4, 32'h80000000, 32'd4,        32'd0,          3,  "SLTU big"};
    vecs[10] = '{4'd8,  5'd4, 32'd3,        32'hFFFFFFFF, 32'd0,          3,  "SLT pos"};
    vecs[11] = '{4'd9,  5'd4, 32'd3,        32'hFFFFFFFF, 32'd1,          3,  "SLTU small"};
    vecs[12] = '{4'd10, 5'd5, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD,   34, "MUL neg"};
    vecs[13] = '{4'd10, 5'd5, 32'd12345,    32'd678,      32'h007FB6F6,   34, "MUL pos"};
    vecs[14] = '{4'd12, 5'd4, 32'd9,        32'd9,        32'd0,          3,  "op12 zero"};

    // Reset state.
    @(negedge clk);
    clr = 1'b1;
    tick();
    tick();
    clr = 1'b0;
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset regwrite", 32'(regwrite), 32'd0);
    check("reset writereg", 32'(writereg), 32'd0);
    check("reset data", data, 32'd0);
    check("reset readreg1", 32'(readreg1), 32'd0);
    check("reset readreg2", 32'(readreg2), 32'd0);

    for (int i = 0; i < 15; i++) begin
      rf[1] = vecs[i].a;
      rf[2] = vecs[i].b;
      run_instr(vecs[i].op, 5'd1, 5'd2, vecs[i].rd, vecs[i].lat, vecs[i].exp, vecs[i].name);
    end

    // rs1 == rs2 feeds both operands from one register.
    rf[1] = 32'd21;
    run_instr(4'd0, 5'd1, 5'd1, 5'd3, 3, 32'd42, "ADD rs1=rs2");

    // rd = 0: done pulses, nothing written.
    rf[1] = 32'd1; rf[2] = 32'd1;
    run_instr(4'd0, 5'd1, 5'd2, 5'd0, 3, 32'd0, "ADD rd0");

    // Reset in the middle of a multiply.
    rf[1] = 32'hFFFFFFFF; rf[2] = 32'd3; rf[5] = 32'hA5A5A5A5;
    for (int i = 0; i < 32; i++) snap[i] = rf[i];
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd10; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd5;
    tick();
    in_valid = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    check("MUL busy at cycle 10", 32'(busy), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr mid-MUL in_ready", 32'(in_ready), 32'd1);
    check("clr mid-MUL busy", 32'(busy), 32'd0);
    check("clr mid-MUL regwrite", 32'(regwrite), 32'd0);
    check("clr mid-MUL readreg1", 32'(readreg1), 32'd0);
    tick();
    tick();
    check("clr mid-MUL no WB", 32'(done | regwrite), 32'd0);
    same = 1'b1;
    for (int i = 0; i < 32; i++) if (rf[i] !== snap[i]) same = 1'b0;
    check("clr mid-MUL rf untouched", 32'(same), 32'd1);
    rf[1] = 32'd7; rf[2] = 32'd5;
    run_instr(4'd0, 5'd1, 5'd2, 5'd3, 3, 32'd12, "ADD after clr");

    // Back-to-back dependent pair with in_valid held high through busy.
    rf[1] = 32'd7; rf[2] = 32'd5; rf[6] = 32'd0; rf[7] = 32'd0;
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'd0; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd6;
    tick();
    in_op = 4'd1; in_rs1 = 5'd6; in_rs2 = 5'd2; in_rd = 5'd7;
    d1 = 0; d2 = 0; ndone = 0; dat1 = '0; dat2 = '0; wr1 = '0; wr2 = '0;
    for (int c = 1; c <= 12; c++) begin
      if (done) begin
        ndone++;
        if (d1 == 0) begin d1 = c; dat1 = data; wr1 = writereg; end
        else if (d2 == 0) begin d2 = c; dat2 = data; wr2 = writereg; end
      end
      if (c == 5) in_valid = 1'b0;
      tick();
    end
    check("b2b first WB cycle", 32'(d1), 32'd3);
    check("b2b first data", dat1, 32'd12);
    check("b2b first writereg", 32'(wr1), 32'd6);
    check("b2b second WB cycle", 32'(d2), 32'd7);
    check("b2b second data", dat2, 32'd7);
    check("b2b second writereg", 32'(wr2), 32'd7);
    check("b2b done count", 32'(ndone), 32'd2);
    check("b2b idle at end", 32'(busy), 32'd0);
    check("b2b rf[6]", rf[6], 32'd12);
    check("b2b rf[7]", rf[7], 32'd7);
    check("rf[0] still zero", rf[0], 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Sequencing execute/writeback stage that sits around the 32x32 register file. It accepts one ALU instruction at a time over a valid/ready handshake and drives the register-file read addresses. It captures the two operands, computes the result (single-cycle ops, or an iterative 32-cycle shift-add multiply), and writes the result back through the register file's write port. It is the consumer of the register file's read outputs and the producer of its writereg/data/regwrite inputs.

Parameters:
DATA_W, 32, operand/result width; all ops are defined for 32.
ADDR_W, 5, register address width.
MUL_CYCLES, 32, number of EXEC iterations for MUL; must equal DATA_W.

Ports:
clk  input  1  single clock; all state updates on posedge.
clr  input  1  synchronous active-high reset, sampled on posedge clk.
in_valid  input  1  instruction offered.
in_ready  output  1  unit can accept an instruction (high only in IDLE).
in_op  input  4  operation code.
in_rs1  input  ADDR_W  source register 1.
in_rs2  input  ADDR_W  source register 2.
in_rd  input  ADDR_W  destination register.
readreg1  output  ADDR_W  to register file read address 1.
readreg2  output  ADDR_W  to register file read address 2.
read1  input  DATA_W  from register file, combinational read data 1.
read2  input  DATA_W  from register file, combinational read data 2.
writereg  output  ADDR_W  to register file write address.
data  output  DATA_W  to register file write data.
regwrite  output  1  to register file write enable.
busy  output  1  instruction in flight (state != IDLE).
done  output  1  one-cycle pulse in the WB cycle.

Behaviour:
- States: IDLE, READ, EXEC, WB. All outputs are registered or decoded from registered state only; there are no combinational paths from inputs to outputs.
- Reset (clr=1 at posedge) returns to IDLE from any state, mid-MUL included. It clears the latched op, rs1, rs2, rd, operands, result and iteration counter. After reset: in_ready=1, busy=0, done=0, regwrite=0, writereg=0, data=0, readreg1=0, readreg2=0.
- IDLE: in_ready=1. On a posedge with in_valid=1, latch op, rs1, rs2 and rd, then go to READ. When in_valid=0, remain in IDLE.
- READ (1 cycle): readreg1=rs1 and readreg2=rs2 come from latched registers. At the closing edge, capture read1 into A and read2 into B, then go to EXEC. Outside READ, readreg1/readreg2 hold their last values.
- EXEC:
  - Non-MUL ops take 1 cycle; result is computed from A and B.
  - MUL: the counter is loaded at EXEC entry. Each cycle, if B[0]=1 then acc+=A; then A<<=1 and B>>=1. After MUL_CYCLES cycles, result = low 32 bits of the product.
  - Leave EXEC for WB when the work is complete.
- Op codes:
  - 0 ADD, 1 SUB (mod 2^32, no flags).
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLL, 6 SRL, 7 SRA; shift amount is B[4:0].
  - 8 SLT (signed, result 0/1), 9 SLTU (unsigned, result 0/1).
  - 10 MUL (low 32 bits, signedness-agnostic).
  - 11..15: result 0, still written back.
- WB (1 cycle): done=1, data=result, writereg=rd.
  - regwrite=1 only if rd != 0; register 0 is never written.
  - Next state is IDLE.
- Outside WB (or when rd=0): regwrite=0, writereg=0, data=0. writereg is held at 0 whenever regwrite=0.
- The register file writes on negedge clk. writereg, data and regwrite are stable for the whole WB cycle, so the write lands mid-WB.
- Latency:
  - Non-MUL: accept at edge E0 → READ in cycle 1, EXEC in cycle 2, WB in cycle 3. in_ready is high again in cycle 4.
  - MUL: WB in cycle 2+MUL_CYCLES = 34.
- Back-to-back: a second instruction can be accepted at the first edge of cycle 4. A dependent instruction reads the updated register because the write completed at the WB negedge.
- in_valid held high while busy is ignored; the offered fields are not latched until in_ready=1.
- rs1=rs2 is legal; A and B receive the same value.

Test Plan:
- Reset then preload r1=7, r2=5; issue ADD rd=3 → regwrite=1, writereg=3, data=12 exactly in cycle 3; done pulse of width 1; in_ready high in cycle 4.
- Preload r1=0x80000000, r2=4; SRA rd=4 → data=0xF8000000. SRL → 0x08000000. SLT(r1,r2) → 1. SLTU → 0.
- Preload r1=0xFFFFFFFF, r2=3; MUL rd=5 → data=0xFFFFFFFD in cycle 34. busy stays high for cycles 1–34; regwrite=0 and writereg=0 before WB.
- ADD rd=0 with r1=1, r2=1 → done pulses, regwrite stays 0, writereg stays 0, r0 reads back as 0.
- Issue MUL, assert clr in EXEC cycle 10 → next cycle: in_ready=1, busy=0, regwrite=0, no register modified; a fresh ADD then completes normally.
- Back-to-back: ADD r6=r1+r2 (7+5), then SUB r7=r6-r2 issued in cycle 4 → r7=7; in_valid held high during busy causes no extra accepts.
